// File: rtl/controller_mem_bus.sv
// CPU memory-bus front end: decodes valid/ready requests to program/data RAM port A,
// the peripheral register bus, or an unmapped-address error, all outputs registered.
module controller_mem_bus #(
  parameter logic [3:0]  PER_NIBBLE = 4'h8,
  parameter int unsigned TIMEOUT    = 256
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_valid,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_wstrb,
  output logic        cpu_ready,
  output logic [31:0] cpu_rdata,
  output logic [11:0] ram_addr,
  output logic [31:0] ram_d,
  output logic        ram_we,
  output logic [3:0]  ram_bytesel,
  input  logic [31:0] ram_q,
  output logic        per_req,
  output logic [31:0] per_addr,
  output logic [31:0] per_wdata,
  output logic [3:0]  per_wstrb,
  input  logic        per_ack,
  input  logic [31:0] per_rdata,
  output logic        bus_err,
  input  logic        bus_err_clr
);

  typedef enum logic [2:0] {
    S_IDLE, S_RAM_ACC, S_RAM_WAIT, S_PER_WAIT, S_DONE
  } state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic        cpu_ready_q, cpu_ready_d;
  logic [31:0] cpu_rdata_q, cpu_rdata_d;
  logic [11:0] ram_addr_q, ram_addr_d;
  logic [31:0] ram_d_q, ram_d_d;
  logic        ram_we_q, ram_we_d;
  logic [3:0]  ram_bytesel_q, ram_bytesel_d;
  logic        per_req_q, per_req_d;
  logic [31:0] per_addr_q, per_addr_d;
  logic [31:0] per_wdata_q, per_wdata_d;
  logic [3:0]  per_wstrb_q, per_wstrb_d;
  logic        bus_err_q, bus_err_d;
  logic        err_set;

  logic sel_ram, sel_per, req_wr, cnt_last;
  assign sel_ram  = (cpu_addr[31:14] == '0);
  assign sel_per  = (cpu_addr[31:28] == PER_NIBBLE);
  assign req_wr   = |cpu_wstrb;
  assign cnt_last = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      wr_q          <= 1'b0;
      cpu_ready_q   <= 1'b0;
      cpu_rdata_q   <= '0;
      ram_addr_q    <= '0;
      ram_d_q       <= '0;
      ram_we_q      <= 1'b0;
      ram_bytesel_q <= '0;
      per_req_q     <= 1'b0;
      per_addr_q    <= '0;
      per_wdata_q   <= '0;
      per_wstrb_q   <= '0;
      bus_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      wr_q          <= wr_d;
      cpu_ready_q   <= cpu_ready_d;
      cpu_rdata_q   <= cpu_rdata_d;
      ram_addr_q    <= ram_addr_d;
      ram_d_q       <= ram_d_d;
      ram_we_q      <= ram_we_d;
      ram_bytesel_q <= ram_bytesel_d;
      per_req_q     <= per_req_d;
      per_addr_q    <= per_addr_d;
      per_wdata_q   <= per_wdata_d;
      per_wstrb_q   <= per_wstrb_d;
      bus_err_q     <= bus_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (cpu_valid) begin
          if (sel_ram)      state_d = S_RAM_ACC;
          else if (sel_per) state_d = S_PER_WAIT;
          else              state_d = S_DONE;
        end
      end
      S_RAM_ACC:  state_d = S_RAM_WAIT;
      S_RAM_WAIT: state_d = S_DONE;
      S_PER_WAIT: if (per_ack || cnt_last) state_d = S_DONE;
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d         = cnt_q;
    wr_d          = wr_q;
    cpu_ready_d   = 1'b0;
    cpu_rdata_d   = cpu_rdata_q;
    ram_addr_d    = ram_addr_q;
    ram_d_d       = ram_d_q;
    ram_we_d      = 1'b0;
    ram_bytesel_d = ram_bytesel_q;
    per_req_d     = per_req_q;
    per_addr_d    = per_addr_q;
    per_wdata_d   = per_wdata_q;
    per_wstrb_d   = per_wstrb_q;
    err_set       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cpu_valid) begin
          wr_d = req_wr;
          if (sel_ram) begin
            ram_addr_d    = cpu_addr[13:2];
            ram_d_d       = cpu_wdata;
            ram_bytesel_d = req_wr ? cpu_wstrb : 4'hF;
            ram_we_d      = req_wr;
          end else if (sel_per) begin
            per_addr_d  = cpu_addr;
            per_wdata_d = cpu_wdata;
            per_wstrb_d = cpu_wstrb;
            per_req_d   = 1'b1;
            cnt_d       = '0;
          end else begin
            cpu_rdata_d = 32'hFFFF_FFFF;
            cpu_ready_d = 1'b1;
            err_set     = 1'b1;
          end
        end
      end
      // ram_q now reflects the address the RAM sampled at the end of RAM_ACC
      S_RAM_WAIT: begin
        cpu_rdata_d = wr_q ? 32'h0 : ram_q;
        cpu_ready_d = 1'b1;
      end
      S_PER_WAIT: begin
        if (per_ack) begin
          cpu_rdata_d = wr_q ? 32'h0 : per_rdata;
          per_req_d   = 1'b0;
          cpu_ready_d = 1'b1;
        end else if (cnt_last) begin
          cpu_rdata_d = 32'hFFFF_FFFF;
          per_req_d   = 1'b0;
          cpu_ready_d = 1'b1;
          err_set     = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: ;
    endcase
    bus_err_d = err_set ? 1'b1 : (bus_err_clr ? 1'b0 : bus_err_q);
  end

  assign cpu_ready   = cpu_ready_q;
  assign cpu_rdata   = cpu_rdata_q;
  assign ram_addr    = ram_addr_q;
  assign ram_d       = ram_d_q;
  assign ram_we      = ram_we_q;
  assign ram_bytesel = ram_bytesel_q;
  assign per_req     = per_req_q;
  assign per_addr    = per_addr_q;
  assign per_wdata   = per_wdata_q;
  assign per_wstrb   = per_wstrb_q;
  assign bus_err     = bus_err_q;

endmodule

// File: tb/tb_controller_mem_bus.sv
// Scoreboard bench for controller_mem_bus with a byte-enabled synchronous RAM model.
module tb_controller_mem_bus;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_valid;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [3:0]  cpu_wstrb;
  logic        cpu_ready;
  logic [31:0] cpu_rdata;
  logic [11:0] ram_addr;
  logic [31:0] ram_d;
  logic        ram_we;
  logic [3:0]  ram_bytesel;
  logic [31:0] ram_q;
  logic        per_req;
  logic [31:0] per_addr, per_wdata;
  logic [3:0]  per_wstrb;
  logic        per_ack;
  logic [31:0] per_rdata;
  logic        bus_err;
  logic        bus_err_clr;

  controller_mem_bus #(.PER_NIBBLE(4'h8), .TIMEOUT(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_valid(cpu_valid), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb),
    .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
    .ram_addr(ram_addr), .ram_d(ram_d), .ram_we(ram_we), .ram_bytesel(ram_bytesel), .ram_q(ram_q),
    .per_req(per_req), .per_addr(per_addr), .per_wdata(per_wdata), .per_wstrb(per_wstrb),
    .per_ack(per_ack), .per_rdata(per_rdata),
    .bus_err(bus_err), .bus_err_clr(bus_err_clr)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: one-cycle read latency, byte-enabled write
  logic [31:0] mem [0:4095];
  initial for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
  always @(posedge clk) begin
    if (ram_we)
      for (int b = 0; b < 4; b++)
        if (ram_bytesel[b]) mem[ram_addr][8*b +: 8] <= ram_d[8*b +: 8];
    ram_q <= mem[ram_addr];
  end

  // Strobe activity counters, sampled on the falling edge
  int          we_cnt = 0;
  int          req_cnt = 0;
  logic [11:0] we_addr = '0;
  logic [3:0]  we_bsel = '0;
  always @(negedge clk) begin
    if (ram_we) begin
      we_cnt  <= we_cnt + 1;
      we_addr <= ram_addr;
      we_bsel <= ram_bytesel;
    end
    if (per_req) req_cnt <= req_cnt + 1;
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    string       name;
  } exp_t;
  exp_t exp_q[$];

  int sb_checks = 0;
  int sb_fail   = 0;
  int d_checks  = 0;
  int d_fail    = 0;

  // Monitor: every ready pulse consumes one expected response
  always @(negedge clk) begin
    exp_t e;
    if (reset_n === 1'b1 && cpu_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        sb_checks++;
        sb_fail++;
        $display("FAIL unexpected_ready: rdata=%08h with no outstanding request", cpu_rdata);
      end else begin
        e = exp_q.pop_front();
        sb_checks++;
        if (cpu_rdata !== e.rdata) begin
          sb_fail++;
          $display("FAIL %s_rdata: got %08h expected %08h", e.name, cpu_rdata, e.rdata);
        end
        sb_checks++;
        if (bus_err !== e.err) begin
          sb_fail++;
          $display("FAIL %s_bus_err: got %0b expected %0b", e.name, bus_err, e.err);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    d_checks++;
    if (act !== exp) begin
      d_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Issue one request; ack_cyc is the cycle after acceptance on which per_ack is driven (0 = never)
  task automatic do_req(input string name, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, input int ack_cyc, input logic [31:0] ack_data,
                        input logic clr_at_accept, input logic [31:0] exp_rdata, input logic exp_err,
                        input int exp_cyc, input int exp_we, input int exp_req);
    int cyc;
    int we0, req0;
    bit done;
    exp_t e;
    e.rdata = exp_rdata; e.err = exp_err; e.name = name;
    exp_q.push_back(e);
    @(negedge clk);
    we0 = we_cnt; req0 = req_cnt;
    cpu_valid = 1'b1; cpu_addr = addr; cpu_wdata = wdata; cpu_wstrb = wstrb;
    bus_err_clr = clr_at_accept;
    @(posedge clk);
    cyc = 1; done = 1'b0;
    while (!done && cyc <= 40) begin
      @(negedge clk);
      bus_err_clr = 1'b0;
      if (cpu_ready === 1'b1) done = 1'b1;
      else begin
        per_ack   = (cyc == ack_cyc);
        per_rdata = ack_data;
        cyc++;
      end
    end
    cpu_valid = 1'b0; cpu_wstrb = 4'h0; per_ack = 1'b0;
    if (!done) begin
      d_checks++; d_fail++;
      $display("FAIL %s_ready_timeout: no cpu_ready within 40 cycles", name);
      void'(exp_q.pop_back());
    end else begin
      chk({name, "_latency"}, 32'(cyc), 32'(exp_cyc));
    end
    chk({name, "_ram_we_pulses"}, 32'(we_cnt - we0), 32'(exp_we));
    chk({name, "_per_req_cycles"}, 32'(req_cnt - req0), 32'(exp_req));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; cpu_valid = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_wstrb = '0;
    per_ack = 1'b0; per_rdata = '0; bus_err_clr = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_cpu_ready", {31'b0, cpu_ready}, 32'h0);
    chk("rst_cpu_rdata", cpu_rdata, 32'h0);
    chk("rst_ram_we", {31'b0, ram_we}, 32'h0);
    chk("rst_ram_addr", {20'b0, ram_addr}, 32'h0);
    chk("rst_per_req", {31'b0, per_req}, 32'h0);
    chk("rst_bus_err", {31'b0, bus_err}, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);

    // RAM full-word write then read back
    do_req("ram_wr", 32'h0000_0010, 32'h1234_5678, 4'hF, 0, 32'h0, 1'b0, 32'h0, 1'b0, 3, 1, 0);
    chk("ram_wr_addr", {20'b0, we_addr}, 32'h4);
    chk("ram_wr_bsel", {28'b0, we_bsel}, 32'hF);
    do_req("ram_rd", 32'h0000_0010, 32'h0, 4'h0, 0, 32'h0, 1'b0, 32'h1234_5678, 1'b0, 3, 0, 0);
    chk("ram_rd_bsel", {28'b0, ram_bytesel}, 32'hF);

    // Single byte lane write
    do_req("ram_bwr", 32'h0000_0010, 32'h0000_AB00, 4'b0010, 0, 32'h0, 1'b0, 32'h0, 1'b0, 3, 1, 0);
    chk("ram_bwr_bsel", {28'b0, we_bsel}, 32'h2);
    do_req("ram_brd", 32'h0000_0010, 32'h0, 4'h0, 0, 32'h0, 1'b0, 32'h1234_AB78, 1'b0, 3, 0, 0);

    // Peripheral read acked on the 3rd wait cycle, then a write acked immediately
    do_req("per_rd", 32'h8000_0004, 32'h0, 4'h0, 3, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 1'b0, 4, 0, 3);
    chk("per_rd_addr", per_addr, 32'h8000_0004);
    chk("per_rd_req_low", {31'b0, per_req}, 32'h0);
    do_req("per_wr", 32'h8000_0008, 32'hDEAD_BEEF, 4'hF, 1, 32'h5555_5555, 1'b0, 32'h0, 1'b0, 2, 0, 1);
    chk("per_wr_wdata", per_wdata, 32'hDEAD_BEEF);
    chk("per_wr_wstrb", {28'b0, per_wstrb}, 32'hF);

    // Timeout with no ack, then clear the error
    do_req("per_to", 32'h8000_000C, 32'h0, 4'h0, 0, 32'h0, 1'b0, 32'hFFFF_FFFF, 1'b1, 9, 0, 8);
    @(negedge clk);
    bus_err_clr = 1'b1;
    @(negedge clk);
    bus_err_clr = 1'b0;
    chk("err_clear", {31'b0, bus_err}, 32'h0);

    // Ack on the final wait cycle beats the timeout
    do_req("per_ack_last", 32'h8000_0010, 32'h0, 4'h0, 8, 32'h0BAD_CAFE, 1'b0, 32'h0BAD_CAFE, 1'b0, 9, 0, 8);

    // Unmapped access, then set-vs-clear in the same cycle
    do_req("unmapped", 32'h4000_0000, 32'h0, 4'h0, 0, 32'h0, 1'b0, 32'hFFFF_FFFF, 1'b1, 1, 0, 0);
    @(negedge clk);
    bus_err_clr = 1'b1;
    @(negedge clk);
    bus_err_clr = 1'b0;
    do_req("set_wins", 32'h4000_0004, 32'h0, 4'h0, 0, 32'h0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1, 0, 0);

    // Reset during PER_WAIT abandons the transaction
    @(negedge clk);
    cpu_valid = 1'b1; cpu_addr = 32'h8000_0020; cpu_wstrb = 4'h0;
    @(posedge clk);
    @(negedge clk);
    cpu_valid = 1'b0;
    @(negedge clk);
    chk("mid_per_req", {31'b0, per_req}, 32'h1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_per_req", {31'b0, per_req}, 32'h0);
    chk("mid_rst_ready", {31'b0, cpu_ready}, 32'h0);
    chk("mid_rst_bus_err", {31'b0, bus_err}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    per_ack = 1'b1; per_rdata = 32'h1111_2222;
    @(negedge clk);
    per_ack = 1'b0;
    chk("late_ack_per_req", {31'b0, per_req}, 32'h0);
    chk("late_ack_ready", {31'b0, cpu_ready}, 32'h0);
    do_req("post_rst_rd", 32'h0000_0010, 32'h0, 4'h0, 0, 32'h0, 1'b0, 32'h1234_AB78, 1'b0, 3, 0, 0);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", d_checks + sb_checks, d_fail + sb_fail);
    $finish;
  end

endmodule
